// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and widths for the data-memory port arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dm_port_arbiter_pkg;

  localparam int DM_ADDR_W = 10;
  localparam int DM_DATA_W = 32;

  // Arbitration mode: who gets precedence when both ports request
  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_EXT_TURN  = 2'd1,
    ST_EXT_BURST = 2'd2
  } dma_state_e;

  // Port that most recently owned the memory (drives the idle address mux)
  typedef enum logic {
    WIN_CPU = 1'b0,
    WIN_EXT = 1'b1
  } winner_e;

endpackage

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and an external loader port.
// Latency: grant is combinational in the request cycle; read data is registered, valid one cycle later.
// Backpressure: the losing port sees gnt=0 (cpu_stall for the CPU) and must hold its request.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int MAX_CPU_STREAK = 4,
  parameter int MAX_EXT_BURST  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [DM_ADDR_W-1:0] cpu_addr,
  input  logic [DM_DATA_W-1:0] cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_stall,
  output logic                 cpu_rvalid,
  output logic [DM_DATA_W-1:0] cpu_rdata,
  input  logic                 ext_req,
  input  logic                 ext_we,
  input  logic [DM_ADDR_W-1:0] ext_addr,
  input  logic [DM_DATA_W-1:0] ext_wdata,
  input  logic                 ext_lock,
  output logic                 ext_gnt,
  output logic                 ext_rvalid,
  output logic [DM_DATA_W-1:0] ext_rdata,
  output logic                 mem_write,
  output logic [DM_ADDR_W-1:0] mem_addr,
  output logic [DM_DATA_W-1:0] write_mem_data,
  input  logic [DM_DATA_W-1:0] read_mem_data
);

  localparam int STREAK_W = $clog2(MAX_CPU_STREAK + 1);
  localparam int BURST_W  = $clog2(MAX_EXT_BURST + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
  localparam logic [BURST_W-1:0]  BURST_MAX  = BURST_W'(MAX_EXT_BURST);
  localparam logic [BURST_W-1:0]  BURST_ONE  = BURST_W'(1);

  dma_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  winner_e             last_q;
  logic                ext_pri;
  logic                sel_ext;

  // Resolve the winner; ext has precedence only during its turn or an unexhausted burst.
  // Grants are forced low while reset is asserted so no access can slip through.
  always_comb begin
    ext_pri = 1'b0;
    case (state_q)
      ST_EXT_TURN:  ext_pri = 1'b1;
      ST_EXT_BURST: ext_pri = (burst_q < BURST_MAX);
      default:      ext_pri = 1'b0;
    endcase
    cpu_gnt = rst_n & cpu_req & ~(ext_req & ext_pri);
    ext_gnt = rst_n & ext_req & ~(cpu_req & ~ext_pri);
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Steer the memory port to the winner, or hold the last winner's address when idle
  always_comb begin
    sel_ext        = ext_gnt | (~cpu_gnt & (last_q == WIN_EXT));
    mem_addr       = sel_ext ? ext_addr  : cpu_addr;
    write_mem_data = sel_ext ? ext_wdata : cpu_wdata;
    mem_write      = (cpu_gnt & cpu_we) | (ext_gnt & ext_we);
  end

  // Count CPU wins that happened while ext was waiting; any ext win or idle ext clears it
  always_comb begin
    streak_d = streak_q;
    if (ext_gnt || !ext_req) begin
      streak_d = '0;
    end else if (cpu_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_ONE;
    end
  end

  // Mode transitions and burst length tracking
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      ST_NORMAL: begin
        burst_d = '0;
        if (ext_gnt && ext_lock) begin
          state_d = ST_EXT_BURST;
          burst_d = BURST_ONE;
        end else if (ext_req && (streak_d == STREAK_MAX)) begin
          state_d = ST_EXT_TURN;
        end
      end
      ST_EXT_TURN: begin
        if (ext_gnt && ext_lock) begin
          state_d = ST_EXT_BURST;
          burst_d = BURST_ONE;
        end else if (ext_gnt || !ext_req) begin
          state_d = ST_NORMAL;
        end
      end
      ST_EXT_BURST: begin
        if (ext_gnt && (burst_q != BURST_MAX)) begin
          burst_d = burst_q + BURST_ONE;
        end
        if (!ext_lock || !ext_req || (burst_d == BURST_MAX)) begin
          state_d = ST_NORMAL;
          burst_d = '0;
        end
      end
      default: begin
        state_d = ST_NORMAL;
        burst_d = '0;
      end
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_NORMAL;
      streak_q <= '0;
      burst_q  <= '0;
      last_q   <= WIN_CPU;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      burst_q  <= burst_d;
      if (ext_gnt) begin
        last_q <= WIN_EXT;
      end else if (cpu_gnt) begin
        last_q <= WIN_CPU;
      end
    end
  end

  // Capture load data at the end of the grant cycle; rdata holds until that port's next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      ext_rvalid <= ext_gnt & ~ext_we;
      if (cpu_gnt && !cpu_we) begin
        cpu_rdata <= read_mem_data;
      end
      if (ext_gnt && !ext_we) begin
        ext_rdata <= read_mem_data;
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for the data-memory port arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: n/a.
// Backpressure: requests are held while not granted, as the MEM stage does.
module tb_dm_port_arbiter;

  localparam int MAXC = 4;
  localparam int MAXB = 8;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        ext_req, ext_we, ext_lock;
  logic [9:0]  ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_write;
  logic [9:0]  mem_addr;
  logic [31:0] write_mem_data, read_mem_data;

  int n_pass;
  int n_total;

  dm_port_arbiter #(.MAX_CPU_STREAK(MAXC), .MAX_EXT_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .write_mem_data(write_mem_data),
    .read_mem_data(read_mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical data memory: synchronous write, combinational read
  logic [31:0] mem [0:1023];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= write_mem_data;
  assign read_mem_data = mem[mem_addr];

  // Reference model: CPU wins ties unless ext is owed a turn or is inside a burst
  int          m_streak;
  int          m_burst;     // ext grants so far in the current burst, 0 = no burst
  bit          m_turn;
  bit          m_last_ext;
  bit          exp_cpu, exp_ext;
  bit          e_cpu_rvalid, e_ext_rvalid;
  logic [31:0] e_cpu_rdata, e_ext_rdata;
  bit          e_cpu_known, e_ext_known;
  logic [31:0] ref_mem [0:1023];
  bit          ref_valid [0:1023];

  task automatic model_reset();
    m_streak = 0; m_burst = 0; m_turn = 0; m_last_ext = 0;
    e_cpu_rvalid = 0; e_ext_rvalid = 0;
    e_cpu_rdata = '0; e_ext_rdata = '0;
    e_cpu_known = 1; e_ext_known = 1;
  endtask

  task automatic model_eval();
    bit ext_first;
    ext_first = m_turn || (m_burst > 0 && m_burst < MAXB);
    exp_cpu = 0; exp_ext = 0;
    if (rst_n) begin
      if (cpu_req && ext_req) begin
        if (ext_first) exp_ext = 1; else exp_cpu = 1;
      end else if (cpu_req) exp_cpu = 1;
      else if (ext_req) exp_ext = 1;
    end
  endtask

  // Advance the model across one clock edge using the inputs of the ending cycle
  task automatic model_clock();
    int new_streak;
    model_eval();
    e_cpu_rvalid = exp_cpu && !cpu_we;
    e_ext_rvalid = exp_ext && !ext_we;
    if (e_cpu_rvalid) begin e_cpu_rdata = ref_mem[cpu_addr]; e_cpu_known = ref_valid[cpu_addr]; end
    if (e_ext_rvalid) begin e_ext_rdata = ref_mem[ext_addr]; e_ext_known = ref_valid[ext_addr]; end
    if (exp_cpu && cpu_we) begin ref_mem[cpu_addr] = cpu_wdata; ref_valid[cpu_addr] = 1; end
    if (exp_ext && ext_we) begin ref_mem[ext_addr] = ext_wdata; ref_valid[ext_addr] = 1; end
    if (exp_ext || !ext_req) new_streak = 0;
    else if (exp_cpu) new_streak = (m_streak < MAXC) ? m_streak + 1 : m_streak;
    else new_streak = m_streak;
    if (m_burst > 0) begin
      if (exp_ext) m_burst++;
      if (!ext_lock || !ext_req || m_burst >= MAXB) m_burst = 0;
    end else if (m_turn) begin
      m_turn = 0;
      if (exp_ext && ext_lock) m_burst = 1;
    end else begin
      if (exp_ext && ext_lock) m_burst = 1;
      else if (new_streak == MAXC && ext_req) m_turn = 1;
    end
    m_streak = new_streak;
    if (exp_ext) m_last_ext = 1; else if (exp_cpu) m_last_ext = 0;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_lock = 0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic test_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h010; cpu_wdata = 32'hFFFF_FFFF;
    ext_req = 1; ext_we = 1; ext_lock = 1; ext_addr = 10'h020; ext_wdata = 32'h1111_1111;
    rst_n = 0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      #2;
      n_total++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write: got %b want 0", mem_write); else n_pass++;
      n_total++; if ({cpu_gnt, ext_gnt} !== 2'b00) $display("FAIL rst_gnts: got %b want 00", {cpu_gnt, ext_gnt}); else n_pass++;
      n_total++; if ({cpu_rvalid, ext_rvalid} !== 2'b00) $display("FAIL rst_rvalids: got %b want 00", {cpu_rvalid, ext_rvalid}); else n_pass++;
      n_total++; if (cpu_rdata !== 32'h0 || ext_rdata !== 32'h0) $display("FAIL rst_rdata: got %h/%h want 0/0", cpu_rdata, ext_rdata); else n_pass++;
      @(posedge clk); #1;
    end
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_store_load();
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h010; cpu_wdata = 32'hDEAD_BEEF;
    #2;
    n_total++; if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) $display("FAIL sl_store_gnt: got gnt=%b stall=%b want 1/0", cpu_gnt, cpu_stall); else n_pass++;
    n_total++; if (mem_write !== 1'b1 || mem_addr !== 10'h010 || write_mem_data !== 32'hDEAD_BEEF)
      $display("FAIL sl_store_port: got we=%b a=%h d=%h want 1/010/deadbeef", mem_write, mem_addr, write_mem_data); else n_pass++;
    tick();
    cpu_we = 0; cpu_wdata = '0;
    #2;
    n_total++; if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0 || mem_write !== 1'b0) $display("FAIL sl_load_gnt: got gnt=%b stall=%b we=%b want 1/0/0", cpu_gnt, cpu_stall, mem_write); else n_pass++;
    n_total++; if (cpu_rvalid !== 1'b0) $display("FAIL sl_no_rvalid_store: got %b want 0", cpu_rvalid); else n_pass++;
    tick();
    cpu_req = 0;
    #2;
    n_total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) $display("FAIL sl_load_data: got v=%b d=%h want 1/deadbeef", cpu_rvalid, cpu_rdata); else n_pass++;
    n_total++; if (cpu_stall !== 1'b0) $display("FAIL sl_stall: got %b want 0", cpu_stall); else n_pass++;
    tick();
    #2;
    n_total++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) $display("FAIL sl_rdata_hold: got v=%b d=%h want 0/deadbeef", cpu_rvalid, cpu_rdata); else n_pass++;
  endtask

  task automatic test_contention();
    bit want_e;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
    ext_req = 1; ext_we = 0; ext_lock = 0; ext_addr = 10'h020;
    for (int i = 0; i < 10; i++) begin
      want_e = (i % 5 == 4);
      #2;
      n_total++; if (cpu_gnt !== !want_e || ext_gnt !== want_e)
        $display("FAIL ct_grant_%0d: got c=%b e=%b want c=%b e=%b", i, cpu_gnt, ext_gnt, !want_e, want_e); else n_pass++;
      n_total++; if (cpu_stall !== want_e) $display("FAIL ct_stall_%0d: got %b want %b", i, cpu_stall, want_e); else n_pass++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_locked_burst();
    ext_req = 1; ext_we = 0; ext_lock = 1; ext_addr = 10'h010;
    cpu_we = 0; cpu_addr = 10'h010;
    for (int i = 0; i < 10; i++) begin
      cpu_req = (i > 0);
      #2;
      n_total++; if (ext_gnt !== (i < 8) || cpu_gnt !== (i >= 8))
        $display("FAIL lb_grant_%0d: got e=%b c=%b want e=%b c=%b", i, ext_gnt, cpu_gnt, (i < 8), (i >= 8)); else n_pass++;
      n_total++; if (ext_rvalid !== (i >= 1 && i <= 8))
        $display("FAIL lb_rvalid_%0d: got %b want %b", i, ext_rvalid, (i >= 1 && i <= 8)); else n_pass++;
      if (i == 1) begin
        n_total++; if (ext_rdata !== 32'hDEAD_BEEF) $display("FAIL lb_rdata: got %h want deadbeef", ext_rdata); else n_pass++;
      end
      tick();
    end
    idle_inputs();
    #2;
    n_total++; if (ext_rvalid !== 1'b0 || cpu_rvalid !== 1'b1) $display("FAIL lb_tail: got e=%b c=%b want 0/1", ext_rvalid, cpu_rvalid); else n_pass++;
    tick();
  endtask

  task automatic test_idle_lock();
    ext_req = 1; ext_we = 1; ext_lock = 1; ext_addr = 10'h3FF; ext_wdata = 32'h1234_5678;
    #2;
    n_total++; if (ext_gnt !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 10'h3FF || write_mem_data !== 32'h1234_5678)
      $display("FAIL il_write: got g=%b we=%b a=%h d=%h want 1/1/3ff/12345678", ext_gnt, mem_write, mem_addr, write_mem_data); else n_pass++;
    tick();
    ext_lock = 0; ext_we = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 10'h3FF;
    #2;
    n_total++; if (ext_gnt !== 1'b1 || cpu_gnt !== 1'b0) $display("FAIL il_burst_hold: got e=%b c=%b want 1/0", ext_gnt, cpu_gnt); else n_pass++;
    tick();
    #2;
    n_total++; if (cpu_gnt !== 1'b1 || ext_gnt !== 1'b0) $display("FAIL il_cpu_wins: got c=%b e=%b want 1/0", cpu_gnt, ext_gnt); else n_pass++;
    n_total++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h1234_5678) $display("FAIL il_ext_read: got v=%b d=%h want 1/12345678", ext_rvalid, ext_rdata); else n_pass++;
    tick();
    idle_inputs();
    #2;
    n_total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1234_5678) $display("FAIL il_cpu_read: got v=%b d=%h want 1/12345678", cpu_rvalid, cpu_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    ext_req = 1; ext_we = 0; ext_lock = 1; ext_addr = 10'h010;
    tick();
    tick();
    ext_we = 1; ext_wdata = 32'hBAD0_BAD0;
    #2;
    n_total++; if (ext_rvalid !== 1'b1 || ext_gnt !== 1'b1) $display("FAIL ar_pre: got v=%b g=%b want 1/1", ext_rvalid, ext_gnt); else n_pass++;
    rst_n = 0;
    model_reset();
    #1;
    n_total++; if (ext_rvalid !== 1'b0 || ext_gnt !== 1'b0 || mem_write !== 1'b0)
      $display("FAIL ar_now: got v=%b g=%b we=%b want 0/0/0", ext_rvalid, ext_gnt, mem_write); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010; ext_we = 0;
    #2;
    n_total++; if (cpu_gnt !== 1'b1 || ext_gnt !== 1'b0) $display("FAIL ar_normal: got c=%b e=%b want 1/0", cpu_gnt, ext_gnt); else n_pass++;
    tick();
    idle_inputs();
    #2;
    n_total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) $display("FAIL ar_no_write: got v=%b d=%h want 1/deadbeef", cpu_rvalid, cpu_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    bit          last_cpu;
    logic [9:0]  want_addr;
    last_cpu = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!(cpu_req && !last_cpu)) begin
        cpu_req   = ($urandom_range(0, 99) < 60);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 10'h100 + 10'($urandom_range(0, 15));
        cpu_wdata = $urandom;
      end
      if ($urandom_range(0, 3) == 0) ext_req = ~ext_req;
      if ($urandom_range(0, 7) == 0) ext_lock = ~ext_lock;
      ext_we    = 1'($urandom_range(0, 1));
      ext_addr  = 10'h100 + 10'($urandom_range(0, 15));
      ext_wdata = $urandom;
      #2;
      model_eval();
      last_cpu = exp_cpu;
      if (exp_ext) want_addr = ext_addr;
      else if (exp_cpu) want_addr = cpu_addr;
      else want_addr = m_last_ext ? ext_addr : cpu_addr;
      n_total++; if (cpu_gnt !== exp_cpu || ext_gnt !== exp_ext)
        $display("FAIL rnd_grant@%0d: got c=%b e=%b want c=%b e=%b", cyc, cpu_gnt, ext_gnt, exp_cpu, exp_ext); else n_pass++;
      n_total++; if (cpu_stall !== (cpu_req && !exp_cpu)) $display("FAIL rnd_stall@%0d: got %b want %b", cyc, cpu_stall, (cpu_req && !exp_cpu)); else n_pass++;
      n_total++; if (mem_write !== ((exp_cpu && cpu_we) || (exp_ext && ext_we)))
        $display("FAIL rnd_we@%0d: got %b want %b", cyc, mem_write, ((exp_cpu && cpu_we) || (exp_ext && ext_we))); else n_pass++;
      n_total++; if (mem_addr !== want_addr) $display("FAIL rnd_addr@%0d: got %h want %h", cyc, mem_addr, want_addr); else n_pass++;
      n_total++; if (cpu_rvalid !== e_cpu_rvalid || ext_rvalid !== e_ext_rvalid)
        $display("FAIL rnd_rvalid@%0d: got c=%b e=%b want c=%b e=%b", cyc, cpu_rvalid, ext_rvalid, e_cpu_rvalid, e_ext_rvalid); else n_pass++;
      if (e_cpu_known) begin
        n_total++; if (cpu_rdata !== e_cpu_rdata) $display("FAIL rnd_cpu_rdata@%0d: got %h want %h", cyc, cpu_rdata, e_cpu_rdata); else n_pass++;
      end
      if (e_ext_known) begin
        n_total++; if (ext_rdata !== e_ext_rdata) $display("FAIL rnd_ext_rdata@%0d: got %h want %h", cyc, ext_rdata, e_ext_rdata); else n_pass++;
      end
      if (cyc % 150 == 149) begin
        rst_n = 0;
        model_reset();
        #1;
        n_total++; if ({cpu_rvalid, ext_rvalid, cpu_gnt, ext_gnt, mem_write} !== 5'b0)
          $display("FAIL rnd_reset@%0d: got %b want 00000", cyc, {cpu_rvalid, ext_rvalid, cpu_gnt, ext_gnt, mem_write}); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1;
        last_cpu = 1;
      end else begin
        tick();
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = '0;
      ref_valid[i] = 0;
    end
    rst_n = 1;
    idle_inputs();
    model_reset();
    #1;
    test_reset();
    test_store_load();
    test_contention();
    test_locked_burst();
    test_idle_lock();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
